// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: turns a byte stream into USB line levels (SYNC, NRZI payload with
// bit stuffing, EOP), one bit per CLKS_PER_BIT clocks, with registered D+/D- outputs.
module usb_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StStuff,
        StEopSe0,
        StEopJ
    } state_e;

    localparam logic [7:0] TimerMax    = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SyncPattern = 8'h80;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] ones_q, ones_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic       prev_q, prev_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       urun_q, urun_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;

    logic wrap;
    logic level;
    logic advance;
    logic accept;

    assign wrap   = (timer_q == TimerMax);
    assign accept = tx_valid && !hold_valid_q;
    // NRZI: prev_q is the level of the previous bit time, 1 meaning J.
    assign level  = shift_q[0] ? prev_q : ~prev_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = wrap ? 8'd0 : timer_q + 8'd1;
        bit_idx_d    = bit_idx_q;
        ones_d       = ones_q;
        shift_d      = shift_q;
        last_d       = last_q;
        prev_d       = prev_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        urun_d       = urun_q;
        advance      = 1'b0;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data;
            hold_last_d  = tx_last;
        end

        case (state_q)
            StIdle: begin
                timer_d = 8'd0;
                if (tx_start && !busy_q) begin
                    state_d   = StSync;
                    shift_d   = SyncPattern;
                    bit_idx_d = 3'd0;
                    ones_d    = 3'd0;
                    last_d    = 1'b0;
                    prev_d    = 1'b1;
                    urun_d    = 1'b0;
                end
            end
            StSync: begin
                if (wrap) begin
                    prev_d  = level;
                    ones_d  = shift_q[0] ? ones_q + 3'd1 : 3'd0;
                    advance = 1'b1;
                end
            end
            StData: begin
                if (wrap) begin
                    prev_d = level;
                    if (!shift_q[0]) begin
                        ones_d  = 3'd0;
                        advance = 1'b1;
                    end else if (ones_q == 3'd5) begin
                        // Sixth consecutive one: the next bit time is a stuffed zero.
                        ones_d  = 3'd0;
                        state_d = StStuff;
                    end else begin
                        ones_d  = ones_q + 3'd1;
                        advance = 1'b1;
                    end
                end
            end
            StStuff: begin
                if (wrap) begin
                    prev_d  = ~prev_q;
                    advance = 1'b1;
                end
            end
            StEopSe0: begin
                if (wrap) begin
                    if (bit_idx_q == 3'd1) begin
                        state_d = StEopJ;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StEopJ: begin
                if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A finished bit (data or stuffed) moves to the next bit or crosses a byte boundary.
        if (advance) begin
            if (bit_idx_q != 3'd7) begin
                bit_idx_d = bit_idx_q + 3'd1;
                shift_d   = {1'b0, shift_q[7:1]};
                state_d   = (state_q == StSync) ? StSync : StData;
            end else if (last_q) begin
                bit_idx_d = 3'd0;
                state_d   = StEopSe0;
            end else if (hold_valid_q) begin
                hold_valid_d = 1'b0;
                shift_d      = hold_data_q;
                last_d       = hold_last_q;
                bit_idx_d    = 3'd0;
                state_d      = StData;
            end else begin
                urun_d    = 1'b1;
                bit_idx_d = 3'd0;
                state_d   = StEopSe0;
            end
        end
    end

    // Output stage: registered one cycle behind the state so every level lasts exactly
    // CLKS_PER_BIT cycles and the status pulses line up with what is on the wire.
    always_comb begin
        dp_d = 1'b1;
        dm_d = 1'b0;
        unique case (state_q)
            StSync, StData: begin
                dp_d = level;
                dm_d = ~level;
            end
            StStuff: begin
                dp_d = ~prev_q;
                dm_d = prev_q;
            end
            StEopSe0: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
            end
            default: begin
                dp_d = 1'b1;
                dm_d = 1'b0;
            end
        endcase
        busy_d     = (state_q != StIdle);
        done_d     = (state_q == StEopJ) && wrap;
        underrun_d = (state_q == StEopSe0) && (timer_q == 8'd0) && (bit_idx_q == 3'd0) && urun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            ones_q       <= 3'd0;
            shift_q      <= 8'd0;
            last_q       <= 1'b0;
            prev_q       <= 1'b1;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'd0;
            hold_last_q  <= 1'b0;
            urun_q       <= 1'b0;
            dp_q         <= 1'b1;
            dm_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            ones_q       <= ones_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            prev_q       <= prev_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            urun_q       <= urun_d;
            dp_q         <= dp_d;
            dm_q         <= dm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_ready    = ~hold_valid_q;
    assign d_plus_out  = dp_q;
    assign d_minus_out = dm_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: expected line levels are written out per bit
// (K, J, 0 for SE0) and checked every clock together with busy/done/underrun.
module tb_usb_tx_serializer;

    localparam int unsigned ClksPerBit = 8;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus_out;
    logic       d_minus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_underrun;

    int n_asserts = 0;
    int n_fail    = 0;

    usb_tx_serializer #(
        .CLKS_PER_BIT(ClksPerBit)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .d_plus_out  (d_plus_out),
        .d_minus_out (d_minus_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {d+, d-, busy, done, underrun}
    function automatic logic [7:0] status();
        return {3'b000, d_plus_out, d_minus_out, tx_busy, tx_done, tx_underrun};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_rise", tx_ready, 8'd1);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        wait_ready();
        tx_data  = data;
        tx_last  = last;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_low_after_accept", tx_ready, 8'd0);
    endtask

    task automatic start_pkt();
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Checks every clock of a packet; urun_cycle is the cycle expecting tx_underrun (-1: none).
    task automatic check_line(input string lv, input int urun_cycle);
        int         total;
        byte        ch;
        logic [1:0] line;
        logic [7:0] exp;
        total = lv.len() * ClksPerBit;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            ch = lv[c / ClksPerBit];
            if (ch == "K") line = 2'b01;
            else if (ch == "J") line = 2'b10;
            else line = 2'b00;
            exp = {3'b000, line, 1'b1, (c == total - 1), (c == urun_cycle)};
            chk($sformatf("line_cycle_%0d", c), status(), exp);
        end
        @(negedge clk);
        chk("back_to_idle", status(), 8'b000_10_000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_status", status(), 8'b000_10_000);
        chk("reset_ready", tx_ready, 8'd1);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-DATA with a byte still waiting in the holding register.
        send_byte(8'h55, 1'b0);
        start_pkt();
        send_byte(8'hAA, 1'b1);
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", tx_busy, 8'd1);
        chk("pre_reset_ready", tx_ready, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_status", status(), 8'b000_10_000);
        chk("mid_reset_ready", tx_ready, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle_%0d", i), status(), 8'b000_10_000);
        end

        // Single byte 0xA5.
        send_byte(8'hA5, 1'b1);
        start_pkt();
        check_line("KJKJKJKKKJJKJJKK00J", -1);

        // 0xFF: stuffed toggle after the fifth data bit.
        send_byte(8'hFF, 1'b1);
        start_pkt();
        check_line("KJKJKJKKKKKKKJJJJ00J", -1);

        // 0x00 then 0x3C, second byte offered once the first has been loaded.
        send_byte(8'h00, 1'b0);
        start_pkt();
        fork
            check_line("KJKJKJKKJKJKJKJKJKKKKKJK00J", -1);
            send_byte(8'h3C, 1'b1);
        join

        // Underrun: 0x12 without tx_last and nothing behind it.
        send_byte(8'h12, 1'b0);
        start_pkt();
        check_line("KJKJKJKKJJKJJKJK00J", 16 * ClksPerBit);

        // tx_start re-asserted mid-packet must not disturb the 0xA5 sequence.
        send_byte(8'hA5, 1'b1);
        start_pkt();
        fork
            check_line("KJKJKJKKKJJKJJKK00J", -1);
            begin
                repeat (40) @(negedge clk);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (60) @(negedge clk);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
